// File: rtl/seq_mult_hs_pkg.sv
// Shared types and helpers for the seq_mult_hs shift-add multiplier.
package seq_mult_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   // Widest vector the conditional negate handles (the 2*WIDTH product path).
   localparam int ABS_MAX_W = 128;

   function automatic int cnt_w_f(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

   // Two's-complement negate when neg is set; callers truncate to their own width.
   function automatic logic [ABS_MAX_W-1:0] cond_neg_f(input logic [ABS_MAX_W-1:0] val,
                                                       input logic                 neg);
      return neg ? (~val + ABS_MAX_W'(1)) : val;
   endfunction

endpackage

// File: rtl/seq_mult_abs.sv
// Conditional two's-complement negate; yields |x| for operands and re-signs the product.
module seq_mult_abs
   import seq_mult_pkg::*;
#(
   parameter int W = 32
) (
   input  logic [W-1:0] val_i,
   input  logic         neg_i,
   output logic [W-1:0] res_o
);

   assign res_o = W'(cond_neg_f(ABS_MAX_W'(val_i), neg_i));

endmodule

// File: rtl/seq_mult_hs.sv
// Iterative shift-add multiplier, one multiplier bit per clock, start/done handshake.
// Optional macro SEQ_MULT_EARLY_TERM_EN finishes once the remaining multiplier bits are zero.
module seq_mult_hs
   import seq_mult_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = cnt_w_f(WIDTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int PW = 2 * WIDTH;

   state_e           state_q;
   logic [WIDTH-1:0] mplier_q;
   logic [PW-1:0]    mcand_q;
   logic [PW-1:0]    acc_q;
   logic [PW-1:0]    acc_d;
   logic [CNT_W-1:0] cnt_q;
   logic             neg_q;
   logic             done_q;
   logic [PW-1:0]    product_q;

   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_abs;
   logic [WIDTH-1:0] b_abs;
   logic [PW-1:0]    res_signed;
   logic             last_bit;
   logic             finish;

   assign a_neg = signed_mode & a[WIDTH-1];
   assign b_neg = signed_mode & b[WIDTH-1];

   seq_mult_abs #(.W(WIDTH)) u_abs_a (.val_i(a), .neg_i(a_neg), .res_o(a_abs));
   seq_mult_abs #(.W(WIDTH)) u_abs_b (.val_i(b), .neg_i(b_neg), .res_o(b_abs));
   seq_mult_abs #(.W(PW))    u_abs_p (.val_i(acc_d), .neg_i(neg_q), .res_o(res_signed));

   assign acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef SEQ_MULT_EARLY_TERM_EN
   // Nothing left to add once the bits still to be shifted in are all zero.
   assign finish = last_bit | (mplier_q[WIDTH-1:1] == '0);
`else
   assign finish = last_bit;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         mplier_q  <= '0;
         mcand_q   <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         neg_q     <= 1'b0;
         done_q    <= 1'b0;
         product_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  mplier_q <= a_abs;
                  mcand_q  <= {{WIDTH{1'b0}}, b_abs};
                  acc_q    <= '0;
                  cnt_q    <= '0;
                  neg_q    <= a_neg ^ b_neg;
                  state_q  <= BUSY;
               end
            end
            BUSY: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + CNT_W'(1);
               if (finish) begin
                  product_q <= res_signed;
                  done_q    <= 1'b1;
                  state_q   <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy    = (state_q == BUSY);
   assign done    = done_q;
   assign product = product_q;

endmodule

// File: tb/tb_seq_mult_hs.sv
// Bench for seq_mult_hs: WIDTH=32 and WIDTH=8 instances, table vectors, corner sequences, random ops.
module tb_seq_mult_hs;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        s32_start, s32_sm, s32_busy, s32_done;
   logic [31:0] s32_a, s32_b;
   logic [63:0] s32_prod;

   logic        s8_start, s8_sm, s8_busy, s8_done;
   logic [7:0]  s8_a, s8_b;
   logic [15:0] s8_prod;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_mult_hs #(.WIDTH(32)) dut32 (
      .clk(clk), .reset(rst_n), .start(s32_start), .signed_mode(s32_sm),
      .a(s32_a), .b(s32_b), .busy(s32_busy), .done(s32_done), .product(s32_prod)
   );

   seq_mult_hs #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(rst_n), .start(s8_start), .signed_mode(s8_sm),
      .a(s8_a), .b(s8_b), .busy(s8_busy), .done(s8_done), .product(s8_prod)
   );

   typedef struct {
      int          w;
      bit          sm;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: plain integer arithmetic on the operands' numeric values.
   function automatic logic [63:0] ref_prod(input int w, input bit sm,
                                            input logic [63:0] a, input logic [63:0] b);
      logic [63:0] wmask, pmask, am, bm;
      longint      sa, sb, p;
      wmask = (64'd1 << w) - 64'd1;
      pmask = (w >= 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
      am = a & wmask;
      bm = b & wmask;
      if (sm) begin
         sa = $signed(am << (64 - w)) >>> (64 - w);
         sb = $signed(bm << (64 - w)) >>> (64 - w);
         p  = sa * sb;
      end else begin
         p = longint'(am * bm);
      end
      return 64'(p) & pmask;
   endfunction

   function automatic int ref_lat(input int w, input bit sm, input logic [63:0] a);
      logic [63:0] wmask, mag;
      int          msb;
      wmask = (64'd1 << w) - 64'd1;
      mag   = (sm && a[w-1]) ? ((~a + 64'd1) & wmask) : (a & wmask);
      msb   = -1;
      for (int i = 0; i < w; i++) if (mag[i]) msb = i;
`ifdef SEQ_MULT_EARLY_TERM_EN
      return (msb < 1) ? 1 : msb + 1;
`else
      return (msb > w) ? 0 : w;
`endif
   endfunction

   function automatic logic cur_busy(input int w);
      return (w == 8) ? s8_busy : s32_busy;
   endfunction

   function automatic logic cur_done(input int w);
      return (w == 8) ? s8_done : s32_done;
   endfunction

   function automatic logic [63:0] cur_prod(input int w);
      return (w == 8) ? {48'd0, s8_prod} : s32_prod;
   endfunction

   task automatic drive_start(input int w, input bit sm, input logic [63:0] a, input logic [63:0] b);
      if (w == 8) begin
         s8_start = 1'b1; s8_sm = sm; s8_a = a[7:0]; s8_b = b[7:0];
      end else begin
         s32_start = 1'b1; s32_sm = sm; s32_a = a[31:0]; s32_b = b[31:0];
      end
   endtask

   // Called #1 after an edge with the DUT idle (or in its done cycle); returns in the done cycle.
   task automatic run_op(input int w, input bit sm, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] prod, output int lat, output int busy_cnt,
                         output bit timeout);
      drive_start(w, sm, a, b);
      @(posedge clk); #1;
      s8_start  = 1'b0;
      s32_start = 1'b0;
      lat = 0; busy_cnt = 0; timeout = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (cur_busy(w)) busy_cnt++;
         @(posedge clk); #1;
         lat++;
         if (cur_done(w)) begin
            timeout = 1'b0;
            break;
         end
      end
      prod = cur_prod(w);
   endtask

   task automatic apply(input string name, input int w, input bit sm, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp);
      logic [63:0] prod;
      int          lat, busy_cnt, exp_lat;
      bit          timeout;
      exp_lat = ref_lat(w, sm, a);
      run_op(w, sm, a, b, prod, lat, busy_cnt, timeout);
      check({name, " timeout"}, 64'(timeout), 64'd0);
      check({name, " product"}, prod, exp);
      check({name, " latency"}, 64'(lat), 64'(exp_lat));
      check({name, " busy cycles"}, 64'(busy_cnt), 64'(exp_lat));
      check({name, " busy at done"}, 64'(cur_busy(w)), 64'd0);
   endtask

   initial begin
      vec_t        vecs[9];
      logic [63:0] ra, rb;
      int          rw, n, done_seen;
      bit          rsm, got_done;

      vecs[0] = '{32, 1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
      vecs[1] = '{32, 1'b1, 64'hFFFF_FFF9, 64'h0000_0006, 64'hFFFF_FFFF_FFFF_FFD6};
      vecs[2] = '{32, 1'b1, 64'h8000_0000, 64'h8000_0000, 64'h4000_0000_0000_0000};
      vecs[3] = '{8,  1'b1, 64'h80, 64'h7F, 64'hC080};
      vecs[4] = '{8,  1'b0, 64'h80, 64'h7F, 64'h3F80};
      vecs[5] = '{32, 1'b0, 64'd5, 64'd9, 64'd45};
      vecs[6] = '{32, 1'b0, 64'd0, 64'hABCD, 64'd0};
      vecs[7] = '{8,  1'b1, 64'hFF, 64'hFF, 64'h0001};
      vecs[8] = '{8,  1'b0, 64'hFF, 64'hFF, 64'hFE01};

      rst_n = 1'b0;
      s32_start = 1'b0; s32_sm = 1'b0; s32_a = '0; s32_b = '0;
      s8_start  = 1'b0; s8_sm  = 1'b0; s8_a  = '0; s8_b  = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset busy32", 64'(s32_busy), 64'd0);
      check("reset done32", 64'(s32_done), 64'd0);
      check("reset prod32", s32_prod, 64'd0);
      check("reset busy8", 64'(s8_busy), 64'd0);
      check("reset done8", 64'(s8_done), 64'd0);
      check("reset prod8", {48'd0, s8_prod}, 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++)
         apply($sformatf("vec%0d", i), vecs[i].w, vecs[i].sm, vecs[i].a, vecs[i].b, vecs[i].exp);

      // Still in the done cycle of the last 32-bit op? Re-sync: run one 32-bit op, then start in its done cycle.
      apply("pre b2b", 32, 1'b1, 64'hFFFF_FFF9, 64'd6, 64'hFFFF_FFFF_FFFF_FFD6);
      check("b2b in done cycle", 64'(s32_done), 64'd1);
      apply("b2b 3x5", 32, 1'b0, 64'd3, 64'd5, 64'd15);

      // Start, operand and mode changes while busy must not disturb the running op.
      drive_start(32, 1'b0, 64'd100, 64'd200);
      @(posedge clk); #1;
      s32_start = 1'b0;
      n = 0; got_done = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (n == 2) begin
            drive_start(32, 1'b1, 64'hFFFF_FFF9, 64'd7);
            check("prod held while busy", s32_prod, 64'd15);
         end
         if (n == 3) s32_start = 1'b0;
         @(posedge clk); #1;
         n++;
         if (s32_done) begin
            got_done = 1'b1;
            break;
         end
      end
      check("ignore start timeout", 64'(got_done), 64'd1);
      check("ignore start product", s32_prod, 64'd20000);
      check("ignore start latency", 64'(n), 64'(ref_lat(32, 1'b0, 64'd100)));
      s32_start = 1'b0;
      @(posedge clk); #1;
      check("no second op busy", 64'(s32_busy), 64'd0);
      check("prod held after done", s32_prod, 64'd20000);

      // Asynchronous reset in the middle of an operation.
      drive_start(32, 1'b0, 64'hFFFF_FFFF, 64'h0001_2345);
      @(posedge clk); #1;
      s32_start = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort busy", 64'(s32_busy), 64'd0);
      check("abort done", 64'(s32_done), 64'd0);
      check("abort prod", s32_prod, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (s32_done) done_seen++;
      end
      check("no done after abort", 64'(done_seen), 64'd0);
      apply("after abort", 32, 1'b1, 64'hFFFF_FFF9, 64'd6, 64'hFFFF_FFFF_FFFF_FFD6);

      for (int i = 0; i < 40; i++) begin
         rw  = ($urandom_range(0, 1) == 1) ? 32 : 8;
         rsm = 1'($urandom_range(0, 1));
         ra  = 64'($urandom);
         rb  = 64'($urandom);
         if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(0, 31);
         if ($urandom_range(0, 7) == 0) ra = '0;
         if (rw == 8) begin
            ra = ra & 64'hFF;
            rb = rb & 64'hFF;
         end
         apply($sformatf("rand%0d w%0d s%0d a=%0h b=%0h", i, rw, rsm, ra, rb),
               rw, rsm, ra, rb, ref_prod(rw, rsm, ra, rb));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
